// File: rtl/bsg_muxn_gatestack_buffered_pkg.sv
// Shared helpers for the buffered per-bit gatestack mux.
// Select field width is derived here so the top keeps it local.
package bsg_muxn_gatestack_buffered_pkg;

    // Clog2 that never returns 0, so a 1-element select still has a field.
    function automatic int safe_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n)
            r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/bsg_muxn_gatestack_buffered_two_fifo.sv
// Two-entry output buffer with valid/ready on input and valid/yumi on output.
// Head is forced to zero when empty so idle outputs stay clean.
module bsg_two_fifo #(
    parameter int width_p = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_r [2];
    logic               wr_ptr_r;
    logic               rd_ptr_r;
    logic [1:0]         cnt_r;
    logic               enq;
    logic               deq;

    assign ready_o = (cnt_r != 2'd2) & ~reset_i;
    assign v_o     = (cnt_r != 2'd0);
    assign data_o  = v_o ? mem_r[rd_ptr_r] : '0;
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (enq)
            mem_r[wr_ptr_r] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else begin
            if (enq)
                wr_ptr_r <= ~wr_ptr_r;
            if (deq)
                rd_ptr_r <= ~rd_ptr_r;
            unique case ({enq, deq})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Consumer may only take the head when there is one.
    assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
        else $error("yumi_i asserted while v_o is low");

endmodule

// File: rtl/bsg_muxn_gatestack_buffered.sv
// Per-bit N-way selector with sticky select register and buffered output.
// Each output bit b picks data_i word sel[b]; out-of-range selects yield 0.
module bsg_muxn_gatestack_buffered
    import bsg_muxn_gatestack_buffered_pkg::*;
#(
    parameter int width_p = 3,
    parameter int els_p   = 2
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   sel_v_i,
    input  logic [width_p*safe_clog2(els_p)-1:0]   sel_i,
    input  logic [els_p*width_p-1:0]               data_i,
    input  logic                                   v_i,
    output logic                                   ready_o,
    output logic [width_p-1:0]                     data_o,
    output logic                                   v_o,
    input  logic                                   yumi_i
);

    localparam int lg_els_lp = safe_clog2(els_p);
    localparam int sel_w_lp  = width_p * lg_els_lp;

    logic [sel_w_lp-1:0] sel_r;
    logic [sel_w_lp-1:0] sel_eff;
    logic [width_p-1:0]  mux_data;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            sel_r <= '0;
        else if (sel_v_i)
            sel_r <= sel_i;
    end

    // A write in the same cycle as a beat steers that beat.
    assign sel_eff = sel_v_i ? sel_i : sel_r;

    for (genvar b = 0; b < width_p; b++) begin : g_bit
        logic [lg_els_lp-1:0] field;
        logic                 bit_val;

        assign field = sel_eff[b*lg_els_lp +: lg_els_lp];

        always_comb begin
            bit_val = 1'b0;
            for (int e = 0; e < els_p; e++) begin
                if (field == lg_els_lp'(e))
                    bit_val = data_i[e*width_p + b];
            end
        end

        assign mux_data[b] = bit_val;
    end

    bsg_two_fifo #(
        .width_p(width_p)
    ) u_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .data_i (mux_data),
        .v_i    (v_i),
        .ready_o(ready_o),
        .data_o (data_o),
        .v_o    (v_o),
        .yumi_i (yumi_i)
    );

endmodule
